// File: rtl/ct_spsram_param_ctrl_pkg.sv
// ct_spsram_pkg: shared definitions for the parametrised SRAM controller.
//   clr_state_e    : clear-engine FSM encoding
//   lane_width()   : bits per write-mask lane
//   rd_lat_legal() : supported read-latency range
//   lanes_legal()  : data width must split evenly into mask lanes
package ct_spsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } clr_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic int lane_width(input int dw, input int we);
        return dw / we;
    endfunction

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic bit lanes_legal(input int dw, input int we);
        return (we > 0) && ((dw % we) == 0);
    endfunction

endpackage

// File: rtl/ct_spsram_param_ctrl_if.sv
// SRAM access bus between a requester (master) and the controller (slave).
// Pin names keep the legacy macro semantics: CEN/GWEN/WEN are active-low.
//   A, CEN, GWEN, WEN, D, INIT_REQ : requester -> controller
//   Q, QVLD, INIT_BUSY, INIT_DONE  : controller -> requester
interface ct_spsram_param_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 128,
    parameter int WE_WIDTH   = 16
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [WE_WIDTH-1:0]   WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  QVLD;
    logic                  INIT_REQ;
    logic                  INIT_BUSY;
    logic                  INIT_DONE;

    modport master (
        output A, CEN, GWEN, WEN, D, INIT_REQ,
        input  Q, QVLD, INIT_BUSY, INIT_DONE
    );

    modport slave (
        input  A, CEN, GWEN, WEN, D, INIT_REQ,
        output Q, QVLD, INIT_BUSY, INIT_DONE
    );
endinterface

// File: rtl/ct_spsram_param_ctrl_rd_pipe.sv
// ct_spsram_rd_pipe: read-data output pipeline with SRAM-style hold.
//   clk_i, rst_i : clock, async active-high reset
//   flush_i      : synchronous drop of all in-flight reads
//   rd_en_i      : a read is captured at this edge
//   rd_data_i    : array word for that read
//   q_o, qvld_o  : held read data and its one-cycle fresh strobe
// Data reaches q_o RD_LAT-1 edges after the capture edge.
module ct_spsram_rd_pipe #(
    parameter int DATA_WIDTH = 128,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  qvld_o
);
    logic [RD_LAT-1:0]     vld_q;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  last_vld;
    logic [DATA_WIDTH-1:0] last_data;

    generate
        if (RD_LAT == 1) begin : g_direct
            assign last_vld  = rd_en_i;
            assign last_data = rd_data_i;
        end else begin : g_stages
            // Intermediate data stages carry no reset: validity lives in vld_q.
            logic [RD_LAT-2:0][DATA_WIDTH-1:0] dat_q;
            always_ff @(posedge clk_i) begin
                dat_q[0] <= rd_data_i;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
            assign last_vld  = vld_q[RD_LAT-2];
            assign last_data = dat_q[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            q_q   <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_en_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            // Q only moves when a read lands, giving macro hold behaviour.
            if (last_vld) begin
                q_q <= last_data;
            end
        end
    end

    assign q_o    = q_q;
    assign qvld_o = vld_q[RD_LAT-1];

endmodule

// File: rtl/ct_spsram_param_ctrl.sv
// ct_spsram_param_ctrl: parametrised single-port SRAM controller.
//   CLK, RST : clock, async active-high reset
//   bus      : slave side of the SRAM bus (address/data/masks, read data
//              with valid strobe, clear-engine request/busy/done)
// Holds the behavioural array, lane-mask merge, access arbitration between
// the external port and the clear engine, and the clear FSM.
module ct_spsram_param_ctrl
    import ct_spsram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 15,
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    WE_WIDTH    = 16,
    parameter int                    RD_LAT      = 1,
    parameter bit                    INIT_ON_RST = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input logic                  CLK,
    input logic                  RST,
    ct_spsram_param_ctrl_if.slave bus
);
    localparam int LW    = lane_width(DATA_WIDTH, WE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
            $error("ct_spsram_param_ctrl: RD_LAT must be in 1..3");
        end
        if (!lanes_legal(DATA_WIDTH, WE_WIDTH)) begin : g_bad_lanes
            $error("ct_spsram_param_ctrl: DATA_WIDTH must be a multiple of WE_WIDTH");
        end
    endgenerate

    clr_state_e            state_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  boot_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_ok;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WE_WIDTH-1:0]   wr_wen;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;

    // External port is locked out for the whole sweep, DONE cycle included.
    assign acc_ok = !bus.CEN && !busy_q;
    assign rd_en  = acc_ok && bus.GWEN;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.A;
        wr_wen  = bus.WEN;
        wr_data = bus.D;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[ADDR_WIDTH-1:0];
            wr_wen  = '0;
            wr_data = INIT_VALUE;
        end else begin
            wr_en   = acc_ok && !bus.GWEN;
        end
    end

    // Read-modify-write merge: masked-off lanes keep the stored value.
    assign old_word = mem[wr_addr];
    always_comb begin
        merged = old_word;
        for (int i = 0; i < WE_WIDTH; i++) begin
            if (!wr_wen[i]) begin
                merged[i*LW +: LW] = wr_data[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= merged;
        end
    end

    // boot_q fires the post-reset sweep on the first edge after release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            boot_q  <= INIT_ON_RST;
        end else begin
            done_q <= 1'b0;
            boot_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.INIT_REQ || boot_q) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Reads in flight when a sweep starts are allowed to drain, so the
    // flush hook stays idle here; reset alone empties the pipe.
    ct_spsram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LAT    (RD_LAT)
    ) u_rd_pipe (
        .clk_i    (CLK),
        .rst_i    (RST),
        .flush_i  (1'b0),
        .rd_en_i  (rd_en),
        .rd_data_i(mem[bus.A]),
        .q_o      (bus.Q),
        .qvld_o   (bus.QVLD)
    );

    assign bus.INIT_BUSY = busy_q;
    assign bus.INIT_DONE = done_q;

endmodule

// File: tb/tb_ct_spsram_param_ctrl.sv
// Bench: two controllers (RD_LAT=2 and RD_LAT=3, depth 16) driven by the
// same stimulus; each has its own expected-read queue checked on QVLD.
module tb_ct_spsram_param_ctrl;
    localparam int AW = 4;
    localparam int DW = 128;
    localparam int WW = 16;
    localparam logic [DW-1:0] IV = {16{8'hA5}};

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [WW-1:0] wen;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] a = '0;
    logic          cen = 1'b1;
    logic          gwen = 1'b1;
    logic [WW-1:0] wen = '1;
    logic [DW-1:0] d = '0;
    logic          init_req = 1'b0;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    exp_t q2[$];
    exp_t q3[$];
    vec_t tbl[12];

    ct_spsram_param_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) if2 ();
    ct_spsram_param_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) if3 ();

    assign if2.A = a;     assign if3.A = a;
    assign if2.CEN = cen; assign if3.CEN = cen;
    assign if2.GWEN = gwen; assign if3.GWEN = gwen;
    assign if2.WEN = wen; assign if3.WEN = wen;
    assign if2.D = d;     assign if3.D = d;
    assign if2.INIT_REQ = init_req; assign if3.INIT_REQ = init_req;

    ct_spsram_param_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .RD_LAT(2),
                           .INIT_ON_RST(1'b1), .INIT_VALUE(IV))
        u_dut2 (.CLK(clk), .RST(rst), .bus(if2));
    ct_spsram_param_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .RD_LAT(3),
                           .INIT_ON_RST(1'b1), .INIT_VALUE(IV))
        u_dut3 (.CLK(clk), .RST(rst), .bus(if3));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboards: data and arrival cycle of every QVLD pulse.
    always @(negedge clk) begin
        exp_t e;
        if (if2.QVLD === 1'b1) begin
            if (q2.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL lat2 unexpected QVLD at cycle %0d", cyc);
            end else begin
                e = q2.pop_front();
                chk("lat2 Q", if2.Q, e.data);
                chk("lat2 cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if3.QVLD === 1'b1) begin
            if (q3.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL lat3 unexpected QVLD at cycle %0d", cyc);
            end else begin
                e = q3.pop_front();
                chk("lat3 Q", if3.Q, e.data);
                chk("lat3 cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        cen = 1'b1; gwen = 1'b1; wen = '1; init_req = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [WW-1:0] w, input logic [DW-1:0] dd);
        @(negedge clk);
        a = ad; cen = 1'b0; gwen = 1'b0; wen = w; d = dd; init_req = 1'b0;
    endtask

    // Read captured at the coming edge (cyc+1); Q lands RD_LAT-1 edges later.
    task automatic rd(input logic [AW-1:0] ad, input logic [DW-1:0] ex);
        @(negedge clk);
        a = ad; cen = 1'b0; gwen = 1'b1; wen = '1; init_req = 1'b0;
        q2.push_back('{ex, cyc + 2});
        q3.push_back('{ex, cyc + 3});
    endtask

    // Observe a sweep over 30 cycles; disturb=1 also throws dropped
    // writes/reads and a second INIT_REQ at the controller mid-sweep.
    task automatic sweep_window(input string tag, input bit disturb);
        int nb2 = 0, nd2 = 0, nb3 = 0, nd3 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if2.INIT_BUSY === 1'b1) nb2++;
            if (if2.INIT_DONE === 1'b1) nd2++;
            if (if3.INIT_BUSY === 1'b1) nb3++;
            if (if3.INIT_DONE === 1'b1) nd3++;
            cen = 1'b1; gwen = 1'b1; wen = '1; init_req = 1'b0;
            if (disturb) begin
                if (i == 8) init_req = 1'b1;
                if (i >= 9 && i <= 14) begin
                    a = 4'd7; cen = 1'b0; gwen = 1'b0; wen = '0; d = 128'hDEAD;
                end
                if (i == 15 || i == 16) begin
                    a = 4'd7; cen = 1'b0; gwen = 1'b1;
                end
            end
        end
        chk({tag, " busy cycles lat2"}, nb2, 17);
        chk({tag, " done pulses lat2"}, nd2, 1);
        chk({tag, " busy cycles lat3"}, nb3, 17);
        chk({tag, " done pulses lat3"}, nd3, 1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd5, 16'h0000, 128'h1234, '0};
        tbl[1]  = '{1'b0, 4'd5, 16'hFFFF, '0, 128'h1234};
        tbl[2]  = '{1'b1, 4'd3, 16'h0000, {DW{1'b1}}, '0};
        tbl[3]  = '{1'b1, 4'd3, 16'hFFFE, '0, '0};
        tbl[4]  = '{1'b0, 4'd3, 16'hFFFF, '0, {{120{1'b1}}, 8'h00}};
        tbl[5]  = '{1'b1, 4'd1, 16'hFF00, 128'h1, '0};
        tbl[6]  = '{1'b0, 4'd1, 16'hFFFF, '0, {{8{8'hA5}}, 64'h1}};
        tbl[7]  = '{1'b1, 4'd2, 16'hFFFF, '0, '0};
        tbl[8]  = '{1'b0, 4'd2, 16'hFFFF, '0, IV};
        tbl[9]  = '{1'b0, 4'd0, 16'hFFFF, '0, IV};
        tbl[10] = '{1'b0, 4'd5, 16'hFFFF, '0, 128'h1234};
        tbl[11] = '{1'b0, 4'd3, 16'hFFFF, '0, {{120{1'b1}}, 8'h00}};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst Q lat2", if2.Q, '0);
        chk("rst QVLD lat2", if2.QVLD, '0);
        chk("rst BUSY lat2", if2.INIT_BUSY, '0);
        chk("rst DONE lat2", if2.INIT_DONE, '0);
        chk("rst Q lat3", if3.Q, '0);
        chk("rst BUSY lat3", if3.INIT_BUSY, '0);

        // Automatic sweep after reset release, then every word holds the fill
        rst = 1'b0;
        sweep_window("boot", 1'b0);
        for (int i = 0; i < 16; i++) rd(AW'(i), IV);
        idle();

        // Vector table, one operation per cycle with no gaps
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wen, tbl[i].d);
            else           rd(tbl[i].addr, tbl[i].exp);
        end
        for (int i = 0; i < 6; i++) idle();
        chk("hold Q lat2", if2.Q, tbl[11].exp);
        chk("hold QVLD lat2", if2.QVLD, '0);
        chk("hold Q lat3", if3.Q, tbl[11].exp);
        chk("hold QVLD lat3", if3.QVLD, '0);

        // Read in flight drains across sweep start; busy accesses are dropped
        rd(4'd5, 128'h1234);
        @(negedge clk);
        cen = 1'b1; init_req = 1'b1;
        sweep_window("req", 1'b1);
        rd(4'd7, IV);
        rd(4'd5, IV);
        rd(4'd3, IV);
        rd(4'd1, IV);
        wr(4'd9, 16'h0000, 128'hBEEF);
        for (int i = 0; i < 5; i++) idle();

        // Reset at cnt=6 mid-sweep, then a full restarted sweep
        @(negedge clk);
        init_req = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            init_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst BUSY lat2", if2.INIT_BUSY, '0);
        chk("midrst QVLD lat2", if2.QVLD, '0);
        chk("midrst Q lat2", if2.Q, '0);
        chk("midrst BUSY lat3", if3.INIT_BUSY, '0);
        chk("midrst QVLD lat3", if3.QVLD, '0);
        @(negedge clk);
        rst = 1'b0;
        sweep_window("restart", 1'b0);
        rd(4'd9, IV);
        rd(4'd0, IV);
        for (int i = 0; i < 8; i++) idle();

        chk("drain lat2", q2.size(), 0);
        chk("drain lat3", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
